// File: rtl/led7seg_pkg.sv
// rtl/led7seg_pkg.sv - shared constants, glyph table and state encoding for the 4-digit scanner
package led7seg_pkg;

  localparam int NUM_DIGITS           = 4;
  localparam int DEFAULT_SCAN_DIV     = 390;
  localparam int DEFAULT_BLANK_CYCLES = 8;
  localparam int CNT_W                = 16;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Active-low glyphs, bit order g..a
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] digits;
    logic [NUM_DIGITS-1:0]      en;
    logic [NUM_DIGITS-1:0]      dots;
  } snap_t;

endpackage

// File: rtl/led7seg_decode.sv
// rtl/led7seg_decode.sv - hex nibble to active-low 7-segment glyph
module led7seg_decode
  import led7seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_hex)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/led7seg_scan.sv
// rtl/led7seg_scan.sv - time-multiplexed 4-digit 7-segment driver with per-slot blanking guard
module led7seg_scan
  import led7seg_pkg::*;
#(
  parameter int SCAN_DIV     = DEFAULT_SCAN_DIV,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic [3:0] I_LED7SEG3,
  input  logic [3:0] I_LED7SEG2,
  input  logic [3:0] I_LED7SEG1,
  input  logic [3:0] I_LED7SEG0,
  input  logic [3:0] I_LEDDRVEN,
  input  logic [3:0] I_LEDDOTS,
  output logic [6:0] O_SEG,
  output logic       O_DP,
  output logic [3:0] O_AN,
  output logic       O_FRAME
);

  generate
    if (BLANK_CYCLES < 1 || SCAN_DIV < BLANK_CYCLES + 1 || SCAN_DIV > 65535) begin : g_bad_params
      $error("led7seg_scan: illegal SCAN_DIV/BLANK_CYCLES combination");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLNK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  snap_t            snap_q, snap_d;
  scan_state_e      state_q, state_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_q, frame_d;
  logic             frame_start;
  logic [6:0]       dec_seg;

  led7seg_decode u_decode (
    .i_hex (snap_q.digits[digit_q]),
    .o_seg (dec_seg)
  );

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) state_q <= ST_BLANK;
    else         state_q <= state_d;
  end

  // State tracks the next counter value so it stays aligned with cnt_q
  always_comb begin
    state_d = (cnt_d < CNT_BLNK) ? ST_BLANK : ST_DRIVE;
  end

  always_comb begin
    an_d    = 4'b1111;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    frame_d = frame_start;
    if (state_q == ST_DRIVE && snap_q.en[digit_q]) begin
      an_d[digit_q] = 1'b0;
      seg_d         = dec_seg;
      dp_d          = ~snap_q.dots[digit_q];
    end
  end

  always_comb begin
    frame_start = (cnt_q == '0) && (digit_q == 2'd0);
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      cnt_d   = cnt_q + 16'd1;
      digit_d = digit_q;
    end
    snap_d = snap_q;
    if (frame_start) begin
      snap_d.digits = {I_LED7SEG3, I_LED7SEG2, I_LED7SEG1, I_LED7SEG0};
      snap_d.en     = I_LEDDRVEN;
      snap_d.dots   = I_LEDDOTS;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      cnt_q   <= '0;
      digit_q <= 2'd0;
      snap_q  <= '0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign O_AN    = an_q;
  assign O_SEG   = seg_q;
  assign O_DP    = dp_q;
  assign O_FRAME = frame_q;

endmodule

// File: tb/tb_led7seg_scan.sv
// tb/tb_led7seg_scan.sv - randomized self-checking bench for led7seg_scan against a frame-level model
module tb_led7seg_scan;

  localparam int SD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = 4 * SD;

  logic       I_CLK = 1'b0;
  logic       I_RESET = 1'b1;
  logic [3:0] I_LED7SEG3 = 4'h0, I_LED7SEG2 = 4'h0, I_LED7SEG1 = 4'h0, I_LED7SEG0 = 4'h0;
  logic [3:0] I_LEDDRVEN = 4'h0, I_LEDDOTS = 4'h0;
  logic [6:0] O_SEG;
  logic       O_DP;
  logic [3:0] O_AN;
  logic       O_FRAME;

  int vectors = 0;
  int miscompares = 0;
  int t = -1;
  logic [3:0] snap_dig [4];
  logic [3:0] snap_en = 4'h0;
  logic [3:0] snap_dots = 4'h0;

  always #5 I_CLK = ~I_CLK;

  led7seg_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
    .I_CLK      (I_CLK),
    .I_RESET    (I_RESET),
    .I_LED7SEG3 (I_LED7SEG3),
    .I_LED7SEG2 (I_LED7SEG2),
    .I_LED7SEG1 (I_LED7SEG1),
    .I_LED7SEG0 (I_LED7SEG0),
    .I_LEDDRVEN (I_LEDDRVEN),
    .I_LEDDOTS  (I_LEDDOTS),
    .O_SEG      (O_SEG),
    .O_DP       (O_DP),
    .O_AN       (O_AN),
    .O_FRAME    (O_FRAME)
  );

  always @(negedge I_CLK)
    if (!I_RESET)
      assert ($countones(~O_AN) <= 1) else $error("FAIL onehot an=%b", O_AN);

  // Glyphs described by which segments are lit, turned into an active-low g..a mask
  function automatic logic [6:0] glyph(input logic [3:0] v);
    string s;
    logic [6:0] m = 7'h7F;
    case (v)
      4'h0: s = "abcdef";  4'h1: s = "bc";      4'h2: s = "abdeg";   4'h3: s = "abcdg";
      4'h4: s = "bcfg";    4'h5: s = "acdfg";   4'h6: s = "acdefg";  4'h7: s = "abc";
      4'h8: s = "abcdefg"; 4'h9: s = "abcdfg";  4'hA: s = "abcefg";  4'hB: s = "cdefg";
      4'hC: s = "adef";    4'hD: s = "bcdeg";   4'hE: s = "adefg";   default: s = "aefg";
    endcase
    for (int i = 0; i < s.len(); i++) m[int'(s[i]) - 97] = 1'b0;
    return m;
  endfunction

  // Expected {an, seg, dp, frame} for output cycle tt after reset release
  function automatic logic [12:0] model(input int tt);
    int pos  = tt % SD;
    int slot = (tt / SD) % 4;
    logic [3:0] an  = 4'hF;
    logic [6:0] seg = 7'h7F;
    logic       dp  = 1'b1;
    if (pos >= BL && snap_en[slot]) begin
      an[slot] = 1'b0;
      seg      = glyph(snap_dig[slot]);
      dp       = ~snap_dots[slot];
    end
    return {an, seg, dp, (tt % FRAME) == 0};
  endfunction

  task automatic step();
    @(posedge I_CLK);
    t++;
    #1;
    if (t % FRAME == 0) begin
      snap_dig[0] = I_LED7SEG0; snap_dig[1] = I_LED7SEG1;
      snap_dig[2] = I_LED7SEG2; snap_dig[3] = I_LED7SEG3;
      snap_en = I_LEDDRVEN; snap_dots = I_LEDDOTS;
    end
  endtask

  task automatic apply_reset();
    I_RESET = 1'b1;
    repeat (2) @(negedge I_CLK);
    I_RESET = 1'b0;
    t = -1;
  endtask

  task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
    I_LED7SEG3 = d3; I_LED7SEG2 = d2; I_LED7SEG1 = d1; I_LED7SEG0 = d0;
  endtask

  task automatic test_reset();
    set_digits(4'hA, 4'h5, 4'h3, 4'h8);
    I_LEDDRVEN = 4'hF; I_LEDDOTS = 4'hF;
    I_RESET = 1'b1;
    repeat (3) @(negedge I_CLK);
    vectors++; if (O_AN !== 4'hF)     begin miscompares++; $display("FAIL reset_an got=%b exp=1111", O_AN); end
    vectors++; if (O_SEG !== 7'h7F)   begin miscompares++; $display("FAIL reset_seg got=%h exp=7f", O_SEG); end
    vectors++; if (O_DP !== 1'b1)     begin miscompares++; $display("FAIL reset_dp got=%b exp=1", O_DP); end
    vectors++; if (O_FRAME !== 1'b0)  begin miscompares++; $display("FAIL reset_frame got=%b exp=0", O_FRAME); end
  endtask

  task automatic test_basic_scan();
    int last_frame = -1;
    set_digits(4'h1, 4'h2, 4'h3, 4'h4);
    I_LEDDRVEN = 4'hF; I_LEDDOTS = 4'h0;
    apply_reset();
    for (int k = 0; k < 3 * FRAME; k++) begin
      step();
      vectors++;
      if ({O_AN, O_SEG, O_DP, O_FRAME} !== model(t)) begin
        miscompares++;
        $display("FAIL basic t=%0d got=%b_%h_%b_%b exp=%b", t, O_AN, O_SEG, O_DP, O_FRAME, model(t));
      end
      if (O_FRAME) begin
        if (last_frame >= 0) begin
          vectors++;
          if (t - last_frame != FRAME) begin
            miscompares++;
            $display("FAIL frame_period got=%0d exp=%0d", t - last_frame, FRAME);
          end
        end
        last_frame = t;
      end
    end
  endtask

  task automatic test_drven_mask();
    set_digits(4'h7, 4'hC, 4'hE, 4'h0);
    I_LEDDRVEN = 4'b1010; I_LEDDOTS = 4'hF;
    apply_reset();
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      vectors++;
      if ({O_AN, O_SEG, O_DP, O_FRAME} !== model(t)) begin
        miscompares++;
        $display("FAIL drven t=%0d got=%b_%h_%b_%b exp=%b", t, O_AN, O_SEG, O_DP, O_FRAME, model(t));
      end
    end
  endtask

  task automatic test_midframe_change();
    set_digits(4'h0, 4'h0, 4'h0, 4'h5);
    I_LEDDRVEN = 4'hF; I_LEDDOTS = 4'h0;
    apply_reset();
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      vectors++;
      if ({O_AN, O_SEG, O_DP, O_FRAME} !== model(t)) begin
        miscompares++;
        $display("FAIL midframe t=%0d got=%b_%h_%b_%b exp=%b", t, O_AN, O_SEG, O_DP, O_FRAME, model(t));
      end
      if (t == 2 || t == SD - 1) begin
        vectors++;
        if (O_SEG !== 7'h12) begin miscompares++; $display("FAIL midframe_old t=%0d got=%h exp=12", t, O_SEG); end
      end
      if (t == FRAME + 2) begin
        vectors++;
        if (O_SEG !== 7'h10) begin miscompares++; $display("FAIL midframe_new t=%0d got=%h exp=10", t, O_SEG); end
      end
      if (t == 12) I_LED7SEG0 = 4'h9;
    end
  endtask

  task automatic test_all_glyphs();
    set_digits(4'h3, 4'h2, 4'h1, 4'h0);
    I_LEDDRVEN = 4'hF; I_LEDDOTS = 4'b0100;
    apply_reset();
    for (int k = 0; k < 4 * FRAME; k++) begin
      step();
      vectors++;
      if ({O_AN, O_SEG, O_DP, O_FRAME} !== model(t)) begin
        miscompares++;
        $display("FAIL glyph t=%0d got=%b_%h_%b_%b exp=%b", t, O_AN, O_SEG, O_DP, O_FRAME, model(t));
      end
      if (t % FRAME == FRAME - 1) begin
        logic [3:0] b;
        b = 4'((t / FRAME + 1) * 4);
        set_digits(b + 4'd3, b + 4'd2, b + 4'd1, b);
      end
    end
  endtask

  task automatic test_reset_midslot();
    set_digits(4'h9, 4'h8, 4'h6, 4'hB);
    I_LEDDRVEN = 4'hF; I_LEDDOTS = 4'h2;
    apply_reset();
    while (t < SD + BL + 4) step();
    vectors++;
    if (O_AN !== 4'b1101) begin miscompares++; $display("FAIL midslot_pre got=%b exp=1101", O_AN); end
    #2 I_RESET = 1'b1;
    #1;
    vectors++;
    if ({O_AN, O_SEG, O_DP, O_FRAME} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL midslot_async got=%b_%h_%b_%b exp=1111_7f_1_0", O_AN, O_SEG, O_DP, O_FRAME);
    end
    @(negedge I_CLK);
    I_RESET = 1'b0;
    t = -1;
    for (int k = 0; k < FRAME + 4; k++) begin
      step();
      vectors++;
      if ({O_AN, O_SEG, O_DP, O_FRAME} !== model(t)) begin
        miscompares++;
        $display("FAIL midslot_restart t=%0d got=%b_%h_%b_%b exp=%b", t, O_AN, O_SEG, O_DP, O_FRAME, model(t));
      end
    end
  endtask

  task automatic test_random(input int frames, input bit rand_en);
    int gap = 0;
    set_digits(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
    I_LEDDRVEN = rand_en ? 4'($urandom_range(15)) : 4'hF;
    I_LEDDOTS  = 4'($urandom_range(15));
    apply_reset();
    for (int k = 0; k < frames * FRAME; k++) begin
      step();
      vectors++;
      if ({O_AN, O_SEG, O_DP, O_FRAME} !== model(t)) begin
        miscompares++;
        $display("FAIL random t=%0d got=%b_%h_%b_%b exp=%b", t, O_AN, O_SEG, O_DP, O_FRAME, model(t));
      end
      if (!rand_en) begin
        if (O_AN == 4'hF) gap++;
        else begin
          if (gap != 0) begin
            vectors++;
            if (gap != BL) begin miscompares++; $display("FAIL blank_gap t=%0d got=%0d exp=%0d", t, gap, BL); end
          end
          gap = 0;
        end
      end
      if ($urandom_range(3) == 0) begin
        set_digits(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
        I_LEDDOTS = 4'($urandom_range(15));
        if (rand_en) I_LEDDRVEN = 4'($urandom_range(15));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_drven_mask();
    test_midframe_change();
    test_all_glyphs();
    test_reset_midslot();
    test_random(1000, 1'b0);
    test_random(50, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
